// File: rtl/frame_integrator_pkg.sv
// Shared constants and state encoding for the frame integrator.
package frame_integrator_pkg;

    localparam int unsigned BITMAP_NB_SEGMENTS = 4;
    localparam int unsigned INTEG_NB_FRAMES    = 8;
    localparam int unsigned INTEG_THRESHOLD    = 2;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } integ_state_e;

endpackage

// File: rtl/frame_integrator_seg_hit_counter.sv
// Per-segment hit counter; 'above' includes the current hit so the closing frame counts.
module seg_hit_counter #(
    parameter int unsigned NB_FRAMES = 8,
    parameter int unsigned THRESHOLD = 2,
    parameter int unsigned CNT_W     = $clog2(NB_FRAMES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc_en,
    input  logic             hit,
    output logic [CNT_W-1:0] cnt,
    output logic             above
);

    logic [CNT_W:0] sum;

    always_comb begin
        sum   = {1'b0, cnt} + {{CNT_W{1'b0}}, hit};
        above = (sum >= (CNT_W + 1)'(THRESHOLD));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc_en) begin
            cnt <= cnt + {{(CNT_W - 1){1'b0}}, hit};
        end
    end

endmodule

// File: rtl/frame_integrator.sv
// Accumulates masked segment frames over a window and emits the thresholded bitmap.
module frame_integrator
    import frame_integrator_pkg::*;
#(
    parameter int unsigned NB_SEGMENTS = BITMAP_NB_SEGMENTS,
    parameter int unsigned NB_FRAMES   = INTEG_NB_FRAMES,
    parameter int unsigned THRESHOLD   = INTEG_THRESHOLD,
    parameter int unsigned CNT_W       = $clog2(NB_FRAMES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [NB_SEGMENTS-1:0] frame,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NB_SEGMENTS-1:0] seg_out,
    output logic [CNT_W-1:0]       frame_idx
);

    integ_state_e           state_q;
    logic                   accept;
    logic                   close;
    logic                   cnt_clr;
    logic [NB_SEGMENTS-1:0] above;

    // clear overrides the handshake, so a frame presented with it is dropped.
    assign accept  = frame_valid & frame_ready & ~clear;
    assign close   = accept & (frame_idx == CNT_W'(NB_FRAMES - 1));
    assign cnt_clr = clear | close;

    for (genvar i = 0; i < NB_SEGMENTS; i++) begin : g_seg
        logic [CNT_W-1:0] cnt;

        seg_hit_counter #(
            .NB_FRAMES (NB_FRAMES),
            .THRESHOLD (THRESHOLD),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (cnt_clr),
            .inc_en (accept),
            .hit    (frame[i]),
            .cnt    (cnt),
            .above  (above[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StInit;
            frame_idx   <= '0;
            seg_out     <= '0;
            out_valid   <= 1'b0;
            frame_ready <= 1'b0;
        end else if (clear) begin
            state_q     <= StAccum;
            frame_idx   <= '0;
            out_valid   <= 1'b0;
            frame_ready <= 1'b1;
        end else begin
            unique case (state_q)
                StInit: begin
                    state_q     <= StAccum;
                    frame_ready <= 1'b1;
                end
                StAccum: begin
                    if (close) begin
                        seg_out     <= above;
                        out_valid   <= 1'b1;
                        frame_idx   <= '0;
                        state_q     <= StHold;
                        frame_ready <= 1'b0;
                    end else if (accept) begin
                        frame_idx <= frame_idx + 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        state_q     <= StAccum;
                        frame_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StInit;
                    frame_ready <= 1'b0;
                    out_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_integrator.sv
// Directed bench for frame_integrator with a reference hit-count model and output scoreboard.
module tb_frame_integrator;

    localparam int unsigned NSEG  = 4;
    localparam int unsigned NFR   = 4;
    localparam int unsigned THR   = 2;
    localparam int unsigned CW    = $clog2(NFR + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_valid;
    logic            frame_ready;
    logic [NSEG-1:0] frame;
    logic            clear;
    logic            out_valid;
    logic            out_ready;
    logic [NSEG-1:0] seg_out;
    logic [CW-1:0]   frame_idx;

    int checks = 0;
    int errors = 0;

    int              m_cnt [NSEG];
    int              m_idx;
    logic [NSEG-1:0] sb [$];

    always #5 clk = ~clk;

    frame_integrator #(
        .NB_SEGMENTS (NSEG),
        .NB_FRAMES   (NFR),
        .THRESHOLD   (THR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame       (frame),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .seg_out     (seg_out),
        .frame_idx   (frame_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSEG; i++) m_cnt[i] = 0;
        m_idx = 0;
    endtask

    task automatic model_accept(input logic [NSEG-1:0] f);
        logic [NSEG-1:0] exp;
        for (int i = 0; i < NSEG; i++) m_cnt[i] += int'(f[i]);
        m_idx++;
        if (m_idx == NFR) begin
            for (int i = 0; i < NSEG; i++) exp[i] = (m_cnt[i] >= THR);
            sb.push_back(exp);
            model_reset();
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the accepting posedge.
    task automatic send_frame(input logic [NSEG-1:0] f);
        frame_valid = 1'b1;
        frame       = f;
        for (int n = 0; n < 20 && !frame_ready; n++) @(negedge clk);
        check("frame_ready_wait", {31'd0, frame_ready}, 32'd1);
        @(posedge clk);
        model_accept(f);
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic check_output(input string tag);
        logic [NSEG-1:0] exp;
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        check({tag, "_seg"}, {28'd0, seg_out}, {28'd0, exp});
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        frame       = '0;
        clear       = 1'b0;
        out_ready   = 1'b1;
        model_reset();

        // Reset and init
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_seg_out", {28'd0, seg_out}, 32'd0);
        check("rst_frame_idx", {29'd0, frame_idx}, 32'd0);
        rst_n = 1'b1;
        check("init_frame_ready", {31'd0, frame_ready}, 32'd0);
        @(negedge clk);
        check("accum_frame_ready", {31'd0, frame_ready}, 32'd1);

        // Basic window, back to back
        send_frame(4'b0011);
        send_frame(4'b0101);
        check("basic_frame_idx", {29'd0, frame_idx}, m_idx);
        send_frame(4'b0001);
        send_frame(4'b1000);
        check_output("basic");
        check("basic_ready_in_hold", {31'd0, frame_ready}, 32'd0);
        @(negedge clk);
        check("basic_pulse_end", {31'd0, out_valid}, 32'd0);
        check("basic_ready_back", {31'd0, frame_ready}, 32'd1);

        // Backpressure
        out_ready = 1'b0;
        send_frame(4'b0011);
        send_frame(4'b0101);
        send_frame(4'b0001);
        send_frame(4'b1000);
        check_output("bp");
        frame_valid = 1'b1;
        frame       = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_seg", {28'd0, seg_out}, 32'h1);
            check("bp_hold_ready", {31'd0, frame_ready}, 32'd0);
            check("bp_hold_idx", {29'd0, frame_idx}, 32'd0);
        end
        out_ready = 1'b1;
        frame_valid = 1'b0;
        @(negedge clk);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, frame_ready}, 32'd1);
        check("bp_release_idx", {29'd0, frame_idx}, 32'd0);

        // Closing frame is counted
        send_frame(4'b0000);
        send_frame(4'b0000);
        send_frame(4'b0000);
        send_frame(4'b1111);
        check_output("close_all1");
        @(negedge clk);
        send_frame(4'b0100);
        send_frame(4'b0100);
        send_frame(4'b0100);
        send_frame(4'b0000);
        check_output("close_seg2");
        @(negedge clk);

        // Clear drops the presented frame and restarts the window
        send_frame(4'b1111);
        send_frame(4'b1111);
        check("clr_pre_idx", {29'd0, frame_idx}, 32'd2);
        clear       = 1'b1;
        frame_valid = 1'b1;
        frame       = 4'b1111;
        @(negedge clk);
        clear       = 1'b0;
        frame_valid = 1'b0;
        model_reset();
        check("clr_idx", {29'd0, frame_idx}, 32'd0);
        check("clr_ready", {31'd0, frame_ready}, 32'd1);
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) send_frame(4'b0001);
        check_output("clr_win");
        @(negedge clk);

        // Reset mid-window
        for (int k = 0; k < 3; k++) send_frame(4'b1111);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("rst2_ready", {31'd0, frame_ready}, 32'd0);
        check("rst2_idx", {29'd0, frame_idx}, 32'd0);
        check("rst2_seg", {28'd0, seg_out}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) send_frame(4'b0010);
        check_output("rst2_win");
        @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
